// File: rtl/arb_pkg.sv
// Shared types and default sizes for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ_DEF = 8;
    localparam int unsigned ID_W_DEF  = 3;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    typedef logic [ID_W_DEF-1:0] req_id_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner pick: lowest requester at or above the pointer,
// falling back to the lowest requester overall.
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned ID_W  = ID_W_DEF
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic             o_win_valid,
    output logic [ID_W-1:0]  o_win_id
);

    logic [N_REQ-1:0] w_masked;
    logic             w_m_valid;
    logic             w_u_valid;
    logic [ID_W-1:0]  w_m_id;
    logic [ID_W-1:0]  w_u_id;

    always_comb begin
        w_masked  = '0;
        w_m_valid = 1'b0;
        w_u_valid = 1'b0;
        w_m_id    = '0;
        w_u_id    = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            w_masked[i] = i_req[i] && (ID_W'(i) >= i_ptr);
        end
        // Scan downwards so the last hit is the lowest index.
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_m_valid = 1'b1;
                w_m_id    = ID_W'(i);
            end
            if (i_req[i]) begin
                w_u_valid = 1'b1;
                w_u_id    = ID_W'(i);
            end
        end
        o_win_valid = w_m_valid | w_u_valid;
        o_win_id    = w_m_valid ? w_m_id : w_u_id;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter sharing one resource among N_REQ requesters; grants held until release.
// Optional grant-hold timeout is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int unsigned N_REQ    = N_REQ_DEF,
    parameter int unsigned ID_W     = ID_W_DEF,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_grant_oh,
    output logic [ID_W-1:0]  o_grant_id,
    output logic             o_grant_valid,
    output logic             o_timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 2..255");
    end
    if (ID_W != $clog2(N_REQ)) begin : g_bad_id_w
        $error("ID_W must equal clog2(N_REQ)");
    end

    arb_state_t       r_state;
    logic [ID_W-1:0]  r_ptr;
    logic [N_REQ-1:0] r_grant_oh;
    logic [ID_W-1:0]  r_grant_id;
    logic             r_grant_valid;
    logic             r_timeout;

    logic             w_req_granted;
    logic             w_revoke;
    logic             w_release;
    logic [ID_W-1:0]  w_ptr_next;
    logic [ID_W-1:0]  w_pick_ptr;
    logic             w_win_valid;
    logic [ID_W-1:0]  w_win_id;
    logic [N_REQ-1:0] w_win_oh;

    assign w_req_granted = i_req[r_grant_id];
    assign w_ptr_next    = (r_grant_id == ID_W'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_hold_cnt;

    assign w_revoke = (r_state == BUSY) && w_req_granted && (r_hold_cnt == 8'(MAX_HOLD - 1));

    // Counts held BUSY cycles; every new grant (from IDLE or a handoff) starts at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold_cnt <= '0;
        end else if (r_state != BUSY || w_release) begin
            r_hold_cnt <= '0;
        end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
        end
    end
`else
    assign w_revoke = 1'b0;
`endif

    assign w_release  = (r_state == BUSY) && (!w_req_granted || w_revoke);
    // A release re-arbitrates in the same edge against the already-advanced pointer.
    assign w_pick_ptr = w_release ? w_ptr_next : r_ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .i_req       (i_req),
        .i_ptr       (w_pick_ptr),
        .o_win_valid (w_win_valid),
        .o_win_id    (w_win_id)
    );

    assign w_win_oh = N_REQ'(1) << w_win_id;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_grant_oh    <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_timeout <= w_revoke;
            unique case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        r_grant_oh    <= w_win_oh;
                        r_grant_id    <= w_win_id;
                        r_grant_valid <= 1'b1;
                        r_state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_release) begin
                        r_ptr <= w_ptr_next;
                        if (w_win_valid) begin
                            r_grant_oh <= w_win_oh;
                            r_grant_id <= w_win_id;
                        end else begin
                            r_grant_oh    <= '0;
                            r_grant_id    <= '0;
                            r_grant_valid <= 1'b0;
                            r_state       <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign o_grant_oh    = r_grant_oh;
    assign o_grant_id    = r_grant_id;
    assign o_grant_valid = r_grant_valid;
    assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed self-checking bench for rr_arbiter_8 (timeout cases when ARB_TIMEOUT_EN is defined).
module tb_rr_arbiter_8;
    import arb_pkg::*;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TbMaxHold = 4;
`else
    localparam int unsigned TbMaxHold = 16;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] grant_oh;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] req;
        logic       valid;
        logic [2:0] id;
        logic [7:0] oh;
        logic       to;
    } vec_t;

    vec_t vecs[11];

    rr_arbiter_8 #(
        .MAX_HOLD (TbMaxHold)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .o_grant_oh    (grant_oh),
        .o_grant_id    (grant_id),
        .o_grant_valid (grant_valid),
        .o_timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic v, input logic [2:0] id,
                         input logic [7:0] oh, input logic to);
        checks++;
        if ({grant_valid, grant_id, grant_oh, timeout} !== {v, id, oh, to}) begin
            errors++;
            $display("FAIL %s: got valid=%0b id=%0d oh=%02h timeout=%0b, want valid=%0b id=%0d oh=%02h timeout=%0b",
                     name, grant_valid, grant_id, grant_oh, timeout, v, id, oh, to);
        end
    endtask

    task automatic check_grant(input string name, input int g, input logic to);
        logic [7:0] oh;
        oh = 8'h01 << g;
        check(name, 1'b1, 3'(g), oh, to);
    endtask

    task automatic check_idle(input string name);
        check(name, 1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    // Apply req, advance one edge, sample 1 time unit later.
    task automatic step(input logic [7:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        rst = 1'b1;
        req = 8'h00;

        // ptr=0 after reset throughout this table.
        vecs[0]  = '{8'h00, 1'b0, 3'd0, 8'h00, 1'b0};  // idle, nothing requested
        vecs[1]  = '{8'h08, 1'b1, 3'd3, 8'h08, 1'b0};  // single request -> 3
        vecs[2]  = '{8'h08, 1'b1, 3'd3, 8'h08, 1'b0};  // held
        vecs[3]  = '{8'h20, 1'b1, 3'd5, 8'h20, 1'b0};  // release 3 (ptr 4), handoff to 5
        vecs[4]  = '{8'h05, 1'b1, 3'd0, 8'h01, 1'b0};  // release 5 (ptr 6), wrap -> 0
        vecs[5]  = '{8'h04, 1'b1, 3'd2, 8'h04, 1'b0};  // release 0 (ptr 1) -> 2
        vecs[6]  = '{8'h00, 1'b0, 3'd0, 8'h00, 1'b0};  // release 2 (ptr 3), idle
        vecs[7]  = '{8'h11, 1'b1, 3'd4, 8'h10, 1'b0};  // ptr 3: 4 beats 0
        vecs[8]  = '{8'h01, 1'b1, 3'd0, 8'h01, 1'b0};  // release 4 (ptr 5), wrap -> 0
        vecs[9]  = '{8'h20, 1'b1, 3'd5, 8'h20, 1'b0};  // release 0 (ptr 1) -> 5
        vecs[10] = '{8'h20, 1'b1, 3'd5, 8'h20, 1'b0};  // held, ptr stays 1

        @(posedge clk);
        #1;
        check_idle("reset_state");
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].req);
            check($sformatf("vec%0d", i), vecs[i].valid, vecs[i].id, vecs[i].oh, vecs[i].to);
        end

        // Asynchronous reset mid-grant (grant 5, ptr 1): outputs clear before the next edge.
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_reset_mid_grant");
        @(posedge clk);
        #1;
        rst = 1'b0;
        // ptr reset to 0 picks 0 over 3.
        step(8'h09);
        check_grant("post_reset_ptr0", 0, 1'b0);
        step(8'h20);
        check_grant("post_reset_handoff_5", 5, 1'b0);
        step(8'h00);
        check_idle("post_reset_idle");

        // Rotation with all requesting; ptr is 6, so first grant from IDLE is 6.
        step(8'hFF);
        g = 6;
        check_grant("rot_first", g, 1'b0);
        for (int k = 0; k < 9; k++) begin
            logic [7:0] drop;
            step(8'hFF);
            check_grant($sformatf("rot_hold%0d", k), g, 1'b0);
            drop = 8'hFF & ~(8'h01 << g);
            step(drop);
            g = (g + 1) % 8;
            check_grant($sformatf("rot_next%0d", k), g, 1'b0);
        end
        // Grant is now 7; drop everything.
        step(8'h00);
        check_idle("rot_end_idle");

`ifndef ARB_TIMEOUT_EN
        // Hold while contended: ptr is 0 now; only 1 requests at first.
        step(8'h02);
        check_grant("hold_start", 1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(8'hFE);
            check_grant($sformatf("hold_cyc%0d", k), 1, 1'b0);
        end
        step(8'hFC);
        check_grant("hold_release_to_2", 2, 1'b0);
        step(8'h00);
        check_idle("hold_end_idle");
`else
        // MAX_HOLD=4: four visible cycles per tenure, revoke edge pulses timeout.
        step(8'h03);
        check_grant("to_g0_c1", 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(8'h03);
            check_grant($sformatf("to_g0_c%0d", k + 2), 0, 1'b0);
        end
        step(8'h03);
        check_grant("to_revoke0_g1", 1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(8'h03);
            check_grant($sformatf("to_g1_c%0d", k + 2), 1, 1'b0);
        end
        step(8'h03);
        check_grant("to_revoke1_g0", 0, 1'b1);
        step(8'h03);
        check_grant("to_pulse_one_cycle", 0, 1'b0);
        step(8'h00);
        check_idle("to_end_idle");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

endmodule
